// File: rtl/switch_input_bus.sv
// switch_input_bus: memory-mapped switch/button input peripheral for the
// 8-bit CPU bus. Synchronises and debounces NUM_INPUTS raw inputs, serves a
// coherent multi-byte snapshot to the CPU, keeps a sticky change flag and
// raises a bus interrupt on any debounced change.
//
// Optional build macro: SWITCH_IRQ_MASK_EN
//   Adds NB read/write interrupt mask bytes after STATUS (reset 8'hFF).
//   Masked bits still debounce and update stable/snapshot; they just do not
//   contribute to the change event.
//
// Address map (offset from BASE_ADDR):
//   0 .. NB-1        debounced value bytes (byte 0 read latches the snapshot)
//   NB               STATUS {7'b0, PENDING}; write bit0=1 clears PENDING
//   NB+1 .. 2*NB     interrupt mask bytes (only with SWITCH_IRQ_MASK_EN)
module switch_input_bus #(
  parameter logic [7:0] BASE_ADDR       = 8'hE0,
  parameter int         NUM_INPUTS      = 16,
  parameter int         DEBOUNCE_CYCLES = 50000,
  parameter int         SYNC_STAGES     = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NUM_INPUTS-1:0] SWITCHES,
  inout  wire  [7:0]            BUS_DATA,
  input  logic [7:0]            BUS_ADDR,
  input  logic                  BUS_WE,
  output logic                  BUS_INTERRUPT_RAISE,
  input  logic                  BUS_INTERRUPT_ACK
);

  localparam int NB = NUM_INPUTS / 8;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [NUM_INPUTS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_INPUTS-1:0] sync_out;
  logic [CW-1:0]         tick_cnt;
  logic                  tick;
  logic [NUM_INPUTS-1:0] hist0, hist1, hist2;
  logic [NUM_INPUTS-1:0] stable_q;
  logic [NUM_INPUTS-1:0] snapshot_q;
  logic [NUM_INPUTS-1:0] upd;
  logic [NUM_INPUTS-1:0] irq_mask;
  logic                  change;
  logic                  pending_q;
  logic                  raise_q;
  logic                  rd_valid_q;
  logic [7:0]            rd_data_q;
  logic [7:0]            offs;
  logic                  hit;
  logic                  rd_hit;
  logic [7:0]            rd_mux;
  logic                  status_clr;
  logic                  unused_bits;

  // Multi-flop synchroniser for the asynchronous switch inputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= SWITCHES;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Free-running sample tick generator, one pulse every DEBOUNCE_CYCLES
  assign tick = (tick_cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RESET)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + CW'(1);
  end

  // A bit flips only when three consecutive tick samples agree on the new level
  assign upd    = ((hist0 & hist1 & hist2) | ~(hist0 | hist1 | hist2)) & (hist0 ^ stable_q);
  assign change = |(upd & irq_mask);

  // Sample history shift on tick; stable value follows agreed history
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hist0    <= '0;
      hist1    <= '0;
      hist2    <= '0;
      stable_q <= '0;
    end else begin
      if (tick) begin
        hist2 <= hist1;
        hist1 <= hist0;
        hist0 <= sync_out;
      end
      stable_q <= stable_q ^ upd;
    end
  end

  // Address decode and read-data selection
  assign offs = BUS_ADDR - BASE_ADDR;

  always_comb begin
    hit    = 1'b0;
    rd_mux = 8'h00;
    for (int k = 0; k < NB; k++) begin
      if (offs == 8'(k)) begin
        hit    = 1'b1;
        rd_mux = (k == 0) ? stable_q[7:0] : snapshot_q[8*k +: 8];
      end
    end
    if (offs == 8'(NB)) begin
      hit    = 1'b1;
      rd_mux = {7'b0, pending_q};
    end
`ifdef SWITCH_IRQ_MASK_EN
    for (int k = 0; k < NB; k++) begin
      if (offs == 8'(NB + 1 + k)) begin
        hit    = 1'b1;
        rd_mux = irq_mask[8*k +: 8];
      end
    end
`endif
  end

  assign rd_hit     = hit & ~BUS_WE;
  assign status_clr = BUS_WE & (offs == 8'(NB)) & BUS_DATA[0];

  // Registered read response; a byte-0 read freezes the other bytes for coherence
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
      snapshot_q <= '0;
    end else begin
      rd_valid_q <= rd_hit;
      if (rd_hit) rd_data_q <= rd_mux;
      if (rd_hit && (offs == 8'd0)) snapshot_q <= stable_q;
    end
  end

  assign BUS_DATA = rd_valid_q ? rd_data_q : 8'hzz;

`ifdef SWITCH_IRQ_MASK_EN
  // CPU-writable interrupt mask bytes
  always_ff @(posedge CLK) begin
    if (RESET) begin
      irq_mask <= '1;
    end else if (BUS_WE) begin
      for (int k = 0; k < NB; k++) begin
        if (offs == 8'(NB + 1 + k)) irq_mask[8*k +: 8] <= BUS_DATA;
      end
    end
  end
`else
  assign irq_mask = '1;
`endif

  // Byte 0 of the snapshot is never read back (byte 0 reads come from stable)
  assign unused_bits = ^{BUS_DATA[7:1], snapshot_q[7:0]};

  // Sticky pending flag and interrupt request; a new change beats any clear
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pending_q <= 1'b0;
      raise_q   <= 1'b0;
    end else begin
      if (change)          pending_q <= 1'b1;
      else if (status_clr) pending_q <= 1'b0;
      if (change)                 raise_q <= 1'b1;
      else if (BUS_INTERRUPT_ACK) raise_q <= 1'b0;
    end
  end

  assign BUS_INTERRUPT_RAISE = raise_q;

endmodule
